// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave register file with byte-strobed writes and registered reads
// Optional: define AXIL_SLV_ERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
  input  logic                           axi_awvalid,
  output logic                           axi_awready,
  input  logic [DATA_WIDTH-1:0]          axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  input  logic                           axi_wvalid,
  output logic                           axi_wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic                           axi_rvalid,
  output logic [1:0]                     axi_rresp,
  input  logic                           axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int IDX_TOP  = ADDR_LSB + IDX_W;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             w_ok, r_ok;
  logic [1:0]       w_resp, r_resp;
  logic             unused_addr;

  assign aw_hs  = axi_awvalid & axi_awready;
  assign w_hs   = axi_wvalid & axi_wready;
  assign b_hs   = bvalid & bready;
  assign ar_hs  = axi_arvalid & axi_arready;
  assign r_hs   = axi_rvalid & axi_rready;
  // Commit only once both holding registers are full, one edge after the last handshake.
  assign commit = (w_state == W_COLLECT) & aw_full & w_full;

  assign w_idx = aw_addr_q[ADDR_LSB +: IDX_W];
  assign r_idx = axi_araddr[ADDR_LSB +: IDX_W];

`ifdef AXIL_SLV_ERR_EN
  assign w_ok   = (aw_addr_q >> IDX_TOP) == '0;
  assign r_ok   = (axi_araddr >> IDX_TOP) == '0;
  assign w_resp = w_ok ? 2'b00 : 2'b10;
  assign r_resp = r_ok ? 2'b00 : 2'b10;
`else
  assign w_ok   = 1'b1;
  assign r_ok   = 1'b1;
  assign w_resp = 2'b00;
  assign r_resp = 2'b00;
`endif

  // Byte-offset bits (and, when aliasing, the upper bits) never select anything.
  assign unused_addr = ^{aw_addr_q, axi_araddr};

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      w_state <= W_COLLECT;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_COLLECT: if (commit) w_state_nxt = W_RESP;
      W_RESP:    if (b_hs)   w_state_nxt = W_COLLECT;
      default:               w_state_nxt = W_COLLECT;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
      default:            r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
    end else if (w_state == W_COLLECT) begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end
      // Each ready stays low from its handshake until the response is consumed.
      axi_awready <= ~(aw_full | aw_hs);
      axi_wready  <= ~(w_full | w_hs);
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= w_resp;
      end
    end else if (b_hs) begin
      bvalid      <= 1'b0;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && w_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) regs[w_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  // Read data samples the pre-commit register value on a same-edge write.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= 2'b00;
    end else if (r_state == R_IDLE) begin
      axi_arready <= ~ar_hs;
      if (ar_hs) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= r_ok ? regs[r_idx] : '0;
        axi_rresp  <= r_resp;
      end
    end else if (r_hs) begin
      axi_rvalid  <= 1'b0;
      axi_arready <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - directed self-checking bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic              aclk = 1'b0;
  logic              arst = 1'b0;
  logic [AW-1:0]     axi_awaddr = '0;
  logic              axi_awvalid = 1'b0;
  logic              axi_awready;
  logic [DW-1:0]     axi_wdata = '0;
  logic [DW/8-1:0]   axi_wstrb = '0;
  logic              axi_wvalid = 1'b0;
  logic              axi_wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [AW-1:0]     axi_araddr = '0;
  logic              axi_arvalid = 1'b0;
  logic              axi_arready;
  logic [DW-1:0]     axi_rdata;
  logic              axi_rvalid;
  logic [1:0]        axi_rresp;
  logic              axi_rready = 1'b0;
  logic [NR*DW-1:0]  regs_out;

  int n_asserts = 0;
  int n_fail    = 0;

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .arst(arst),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rresp(axi_rresp), .axi_rready(axi_rready),
    .regs_out(regs_out)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_at(input int i);
    return regs_out[i*DW +: DW];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, input logic [1:0] exp_resp, input string tag);
    bit aw_done = 0;
    bit w_done  = 0;
    int t = 0;
    axi_awaddr = addr; axi_awvalid = 1'b1;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
    bready = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      @(negedge aclk);
      if (axi_awvalid && axi_awready) aw_done = 1;
      if (axi_wvalid && axi_wready) w_done = 1;
      @(posedge aclk); #1;
      if (aw_done) axi_awvalid = 1'b0;
      if (w_done) axi_wvalid = 1'b0;
      t++;
    end
    chk({tag, "_hs"}, aw_done && w_done, 1);
    t = 0;
    while (!bvalid && t < 20) begin
      cyc(1);
      t++;
    end
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp_resp);
    cyc(1);
    chk({tag, "_bclr"}, bvalid, 0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    bit done = 0;
    int t = 0;
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b1;
    while (!done && t < 20) begin
      @(negedge aclk);
      if (axi_arready) done = 1;
      @(posedge aclk); #1;
      t++;
    end
    axi_arvalid = 1'b0;
    chk({tag, "_hs"}, done, 1);
    chk({tag, "_rvalid"}, axi_rvalid, 1);
    chk({tag, "_rdata"}, axi_rdata, exp_data);
    chk({tag, "_rresp"}, axi_rresp, exp_resp);
    cyc(1);
    chk({tag, "_rclr"}, axi_rvalid, 0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_awready", axi_awready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_arready", axi_arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_regs", regs_out, 0);
    repeat (2) @(posedge aclk);
    #1 arst = 1'b1;
    chk("rel_awready_pre", axi_awready, 0);
    cyc(1);
    chk("rel_awready", axi_awready, 1);
    chk("rel_wready", axi_wready, 1);
    chk("rel_arready", axi_arready, 1);

    // 1: AW and W on the same edge, bready already high
    axi_awaddr = 32'h10; axi_awvalid = 1'b1;
    axi_wdata = 32'hA5A51234; axi_wstrb = 4'hF; axi_wvalid = 1'b1; bready = 1'b1;
    cyc(1);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("s1_awready_low", axi_awready, 0);
    chk("s1_wready_low", axi_wready, 0);
    chk("s1_no_bvalid_yet", bvalid, 0);
    chk("s1_reg4_before", reg_at(4), 0);
    cyc(1);
    chk("s1_bvalid", bvalid, 1);
    chk("s1_bresp", bresp, 2'b00);
    chk("s1_reg4", reg_at(4), 32'hA5A51234);
    chk("s1_awready_resp", axi_awready, 0);
    cyc(1);
    chk("s1_bclr", bvalid, 0);
    chk("s1_awready_back", axi_awready, 1);
    chk("s1_wready_back", axi_wready, 1);

    // 2: W first, AW three cycles later
    axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'b0011; axi_wvalid = 1'b1;
    cyc(1);
    axi_wvalid = 1'b0;
    chk("s2_wready_low", axi_wready, 0);
    chk("s2_awready_hi", axi_awready, 1);
    cyc(3);
    chk("s2_no_commit", reg_at(4), 32'hA5A51234);
    chk("s2_no_bvalid", bvalid, 0);
    axi_awaddr = 32'h10; axi_awvalid = 1'b1;
    cyc(1);
    axi_awvalid = 1'b0;
    chk("s2_no_bvalid_aw", bvalid, 0);
    cyc(1);
    chk("s2_bvalid", bvalid, 1);
    chk("s2_reg4", reg_at(4), 32'hA5A5BEEF);
    cyc(1);
    chk("s2_bclr", bvalid, 0);

    // 3: read with rready held low for 4 cycles
    axi_araddr = 32'h10; axi_arvalid = 1'b1; axi_rready = 1'b0;
    cyc(1);
    axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s3_rvalid_hold", axi_rvalid, 1);
      chk("s3_rdata_hold", axi_rdata, 32'hA5A5BEEF);
      chk("s3_arready_low", axi_arready, 0);
      cyc(1);
    end
    chk("s3_rresp", axi_rresp, 2'b00);
    axi_rready = 1'b1;
    cyc(1);
    chk("s3_rclr", axi_rvalid, 0);
    chk("s3_arready_back", axi_arready, 1);

    // 4: out-of-range write/read
`ifdef AXIL_SLV_ERR_EN
    axi_write(32'h400, 32'hCAFEF00D, 4'hF, 2'b10, "s4_wr");
    chk("s4_reg0", reg_at(0), 0);
    chk("s4_reg4", reg_at(4), 32'hA5A5BEEF);
    axi_read(32'h400, 32'h0, 2'b10, "s4_rd");
`else
    axi_write(32'h400, 32'hCAFEF00D, 4'hF, 2'b00, "s4_wr");
    chk("s4_reg0", reg_at(0), 32'hCAFEF00D);
    chk("s4_reg4", reg_at(4), 32'hA5A5BEEF);
    axi_read(32'h404, 32'h0, 2'b00, "s4_rd_alias1");
    axi_read(32'h400, 32'hCAFEF00D, 2'b00, "s4_rd");
`endif

    // 5: read and write commit of reg[2] on the same edge
    axi_write(32'h08, 32'h22222222, 4'hF, 2'b00, "s5_pre");
    axi_awaddr = 32'h08; axi_awvalid = 1'b1;
    axi_wdata = 32'h11111111; axi_wstrb = 4'hF; axi_wvalid = 1'b1; bready = 1'b1;
    cyc(1);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_araddr = 32'h08; axi_arvalid = 1'b1; axi_rready = 1'b0;
    cyc(1);
    axi_arvalid = 1'b0;
    chk("s5_rvalid", axi_rvalid, 1);
    chk("s5_rdata_old", axi_rdata, 32'h22222222);
    chk("s5_reg2_new", reg_at(2), 32'h11111111);
    chk("s5_bvalid", bvalid, 1);
    axi_rready = 1'b1;
    cyc(1);
    chk("s5_rclr", axi_rvalid, 0);
    axi_read(32'h08, 32'h11111111, 2'b00, "s5_reread");

    // 6: reset while holding a write response
    axi_awaddr = 32'h14; axi_awvalid = 1'b1;
    axi_wdata = 32'h55555555; axi_wstrb = 4'hF; axi_wvalid = 1'b1; bready = 1'b0;
    cyc(1);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    cyc(3);
    chk("s6_bvalid_held", bvalid, 1);
    chk("s6_reg5", reg_at(5), 32'h55555555);
    #2 arst = 1'b0;
    #1;
    chk("s6_bvalid_rst", bvalid, 0);
    chk("s6_awready_rst", axi_awready, 0);
    chk("s6_wready_rst", axi_wready, 0);
    chk("s6_arready_rst", axi_arready, 0);
    chk("s6_regs_rst", regs_out, 0);
    @(posedge aclk);
    #1 arst = 1'b1;
    cyc(1);
    chk("s6_awready_back", axi_awready, 1);
    chk("s6_arready_back", axi_arready, 1);
    axi_write(32'h04, 32'h0BADF00D, 4'b1100, 2'b00, "s6_wr");
    chk("s6_reg1", reg_at(1), 32'h0BAD0000);
    axi_read(32'h04, 32'h0BAD0000, 2'b00, "s6_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
